// File: rtl/xreal_decim_sampler_if.sv
// Downstream result channel of xreal_decim_sampler: window sum on a valid/ready handshake.
interface xreal_decim_sampler_if #(
  parameter int SW = 10
);
  logic signed [SW-1:0] sum;
  logic                 sum_valid;
  logic                 sum_ready;

  modport master (output sum, output sum_valid, input  sum_ready);
  modport slave  (input  sum, input  sum_valid, output sum_ready);
endinterface

// File: rtl/xreal_decim_sampler.sv
// Samples a real-valued analog input, quantizes to a saturated signed code and integrates DECIM codes per window.
// Optional sticky clip flag port sat_o when XDS_SAT_FLAG_EN is defined.
module xreal_decim_sampler #(
  parameter int  NBITS = 8,
  parameter real LSB   = 1.0/128.0,
  parameter int  DECIM = 4,
  parameter int  SW    = NBITS + $clog2(DECIM)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  real                     in_i,
  output logic signed [NBITS-1:0] code_o,
  output logic                    overrun_o,
`ifdef XDS_SAT_FLAG_EN
  output logic                    sat_o,
`endif
  xreal_decim_sampler_if.master   dn
);

  localparam int  CW   = $clog2(DECIM);
  localparam int  QMAX = (1 << (NBITS-1)) - 1;
  localparam int  QMIN = -(1 << (NBITS-1));
  localparam real QLIM = real'(1 << NBITS);

  typedef enum logic {S_FILL, S_DUMP} phase_e;

  real                     xs;
  int                      qr;
  logic signed [NBITS-1:0] q;
  logic                    q_clip;

  logic [CW-1:0]           cnt_q, cnt_d;
  logic signed [SW-1:0]    acc_q, acc_d, win_sum;
  logic signed [SW-1:0]    sum_q, sum_d;
  logic                    vld_q, vld_d;
  logic                    ovr_q, ovr_d;
  logic signed [NBITS-1:0] code_q;
  phase_e                  phase;

  // Pre-limit the scaled value so the real-to-int conversion cannot overflow
  always_comb begin
    xs = in_i / LSB;
    if (xs > QLIM)  xs = QLIM;
    if (xs < -QLIM) xs = -QLIM;
    if (xs >= 0.0) qr = $rtoi(xs + 0.5);
    else           qr = -$rtoi(0.5 - xs);
    q_clip = (qr > QMAX) || (qr < QMIN);
    if (qr > QMAX)      q = NBITS'(QMAX);
    else if (qr < QMIN) q = NBITS'(QMIN);
    else                q = NBITS'(qr);
  end

  // DUMP is the edge on which the last sample of the window arrives
  assign phase   = (cnt_q == CW'(DECIM-1)) ? S_DUMP : S_FILL;
  assign win_sum = acc_q + {{(SW-NBITS){q[NBITS-1]}}, q};

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    acc_d = win_sum;
    if (phase == S_DUMP) begin
      cnt_d = '0;
      acc_d = '0;
    end
  end

  always_comb begin
    sum_d = sum_q;
    vld_d = vld_q;
    ovr_d = ovr_q;
    if (phase == S_DUMP) begin
      if (!vld_q || dn.sum_ready) begin
        sum_d = win_sum;
        vld_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (vld_q && dn.sum_ready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      sum_q  <= '0;
      vld_q  <= 1'b0;
      ovr_q  <= 1'b0;
      code_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      sum_q  <= sum_d;
      vld_q  <= vld_d;
      ovr_q  <= ovr_d;
      code_q <= q;
    end
  end

`ifdef XDS_SAT_FLAG_EN
  logic sat_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sat_q <= 1'b0;
    else     sat_q <= sat_q | q_clip;
  end
  assign sat_o = sat_q;
`else
  logic unused_clip;
  assign unused_clip = q_clip;
`endif

  assign code_o       = code_q;
  assign overrun_o    = ovr_q;
  assign dn.sum       = sum_q;
  assign dn.sum_valid = vld_q;

endmodule

// File: tb/tb_xreal_decim_sampler.sv
// Self-checking bench: directed vector table, hand-written corner sequences, sine and random stimulus vs a window model.
module tb_xreal_decim_sampler;
  localparam int  NBITS = 8;
  localparam int  DECIM = 4;
  localparam int  SW    = 10;
  localparam real LSB   = 1.0/128.0;
  localparam real PI    = 3.14159265358979;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  real                     x   = 0.0;
  logic signed [NBITS-1:0] code;
  logic                    overrun;
`ifdef XDS_SAT_FLAG_EN
  logic                    sat;
`endif

  xreal_decim_sampler_if #(.SW(SW)) dn();

  xreal_decim_sampler #(.NBITS(NBITS), .LSB(LSB), .DECIM(DECIM), .SW(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_i      (x),
    .code_o    (code),
    .overrun_o (overrun),
`ifdef XDS_SAT_FLAG_EN
    .sat_o     (sat),
`endif
    .dn        (dn)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int m_code, m_sum;
  bit m_vld, m_ovr, m_sat;
  int win[$];

  typedef struct {
    real x;
    bit  rdy;
    int  code;
    int  sum;
    bit  vld;
    bit  ovr;
  } vec_t;
  vec_t tv[16];

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Round half away from zero on the ideal scaled value, no clamping
  function automatic int mround(input real v);
    real s;
    s = v / LSB;
    if (s >= 0.0) s = $floor(s + 0.5);
    else          s = $ceil(s - 0.5);
    return $rtoi(s);
  endfunction

  task automatic model_reset();
    m_code = 0; m_sum = 0; m_vld = 0; m_ovr = 0; m_sat = 0;
    win.delete();
  endtask

  task automatic model_step(input real v, input bit r);
    int u, qv, s;
    u  = mround(v);
    qv = (u > 127) ? 127 : (u < -128) ? -128 : u;
    if (qv != u) m_sat = 1;
    m_code = qv;
    win.push_back(qv);
    if (win.size() == DECIM) begin
      s = 0;
      foreach (win[i]) s += win[i];
      win.delete();
      if (!m_vld || r) begin m_sum = s; m_vld = 1; end
      else m_ovr = 1;
    end else if (m_vld && r) begin
      m_vld = 0;
    end
  endtask

  task automatic tick(input real v, input bit r);
    x = v;
    dn.sum_ready = r;
    @(posedge clk);
    #1;
    model_step(v, r);
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".code"},    int'(code),          m_code);
    chk({tag, ".sum"},     int'(dn.sum),        m_sum);
    chk({tag, ".valid"},   int'(dn.sum_valid),  int'(m_vld));
    chk({tag, ".overrun"}, int'(overrun),       int'(m_ovr));
`ifdef XDS_SAT_FLAG_EN
    chk({tag, ".sat"},     int'(sat),           int'(m_sat));
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    x = 0.0;
    dn.sum_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    model_reset();
  endtask

  initial begin
    dn.sum_ready = 1'b1;
    #1;
    chk("rst.code",    int'(code),         0);
    chk("rst.sum",     int'(dn.sum),       0);
    chk("rst.valid",   int'(dn.sum_valid), 0);
    chk("rst.overrun", int'(overrun),      0);
    @(posedge clk);
    #2 rst = 1'b0;
    model_reset();

    // Constant, saturation and rounding windows, ready held high
    tv[0]  = '{0.5,  1,  64,    0, 0, 0};
    tv[1]  = '{0.5,  1,  64,    0, 0, 0};
    tv[2]  = '{0.5,  1,  64,    0, 0, 0};
    tv[3]  = '{0.5,  1,  64,  256, 1, 0};
    tv[4]  = '{1.2,  1, 127,  256, 0, 0};
    tv[5]  = '{1.2,  1, 127,  256, 0, 0};
    tv[6]  = '{1.2,  1, 127,  256, 0, 0};
    tv[7]  = '{1.2,  1, 127,  508, 1, 0};
    tv[8]  = '{-2.0, 1, -128, 508, 0, 0};
    tv[9]  = '{-2.0, 1, -128, 508, 0, 0};
    tv[10] = '{-2.0, 1, -128, 508, 0, 0};
    tv[11] = '{-2.0, 1, -128, -512, 1, 0};
    tv[12] = '{0.5*LSB,  1,  1, -512, 0, 0};
    tv[13] = '{-0.5*LSB, 1, -1, -512, 0, 0};
    tv[14] = '{0.49*LSB, 1,  0, -512, 0, 0};
    tv[15] = '{0.0,      1,  0,    0, 1, 0};
    for (int i = 0; i < 16; i++) begin
      tick(tv[i].x, tv[i].rdy);
      chk($sformatf("tv%0d.code", i),    int'(code),         tv[i].code);
      chk($sformatf("tv%0d.sum", i),     int'(dn.sum),       tv[i].sum);
      chk($sformatf("tv%0d.valid", i),   int'(dn.sum_valid), int'(tv[i].vld));
      chk($sformatf("tv%0d.overrun", i), int'(overrun),      int'(tv[i].ovr));
    end
`ifdef XDS_SAT_FLAG_EN
    chk("tv.sat", int'(sat), 1);
`endif

    // Backpressure through two windows
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      tick(0.25, 1'b0);
      if (i == 4) begin
        chk("bp.w1.sum",     int'(dn.sum),       128);
        chk("bp.w1.valid",   int'(dn.sum_valid), 1);
        chk("bp.w1.overrun", int'(overrun),      0);
      end
    end
    chk("bp.w2.overrun", int'(overrun),      1);
    chk("bp.w2.sum",     int'(dn.sum),       128);
    chk("bp.w2.valid",   int'(dn.sum_valid), 1);
    tick(0.25, 1'b1);
    chk("bp.drain.valid", int'(dn.sum_valid), 0);
    chk("bp.drain.sum",   int'(dn.sum),       128);

    // Accept and dump on the same edge
    do_reset();
    repeat (4) tick(0.25, 1'b0);
    repeat (3) tick(0.5, 1'b0);
    tick(0.5, 1'b1);
    chk("ad.sum",     int'(dn.sum),       256);
    chk("ad.valid",   int'(dn.sum_valid), 1);
    chk("ad.overrun", int'(overrun),      0);

    // Asynchronous reset in the middle of a window
    do_reset();
    repeat (6) tick(0.5, 1'b1);
    chk("mr.pre.code", int'(code),   64);
    chk("mr.pre.sum",  int'(dn.sum), 256);
    #2 rst = 1'b1;
    #1;
    chk("mr.code",    int'(code),         0);
    chk("mr.sum",     int'(dn.sum),       0);
    chk("mr.valid",   int'(dn.sum_valid), 0);
    chk("mr.overrun", int'(overrun),      0);
    @(posedge clk);
    #2 rst = 1'b0;
    model_reset();
    repeat (3) tick(0.125, 1'b1);
    chk("mr.fill.valid", int'(dn.sum_valid), 0);
    tick(0.125, 1'b1);
    chk("mr.post.code",  int'(code),         16);
    chk("mr.post.sum",   int'(dn.sum),       64);
    chk("mr.post.valid", int'(dn.sum_valid), 1);

    // Two-tone sine sampled at 1 GHz, 1000 windows
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      real t, v;
      t = real'(n) * 1.0e-9;
      v = $sin(2.0*PI*50.0e6*t) + 0.2*$sin(2.0*PI*500.0e6*t);
      tick(v, 1'b1);
      check_model("sine");
    end

    // Random input with random backpressure
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      real v;
      bit  r;
      v = real'(int'($urandom_range(0, 3000)) - 1500) / 1000.0;
      r = ($urandom_range(0, 3) != 0);
      tick(v, r);
      check_model("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/xreal_decim_sampler.md
# xreal_decim_sampler

Clocked sampler that is the digital consumer of the summed analog waveform from the xreal adder stage in the neuron front-end benches. On every rising clock edge it samples an `xreal` input, quantizes it to a saturated signed code, and accumulates DECIM consecutive codes (integrate-and-dump). Each completed window sum is offered downstream on a valid/ready handshake. It is the boundary where the continuous XMODEL signal path becomes the digital neuron datapath.

## Interface
- `NBITS`, 8: quantizer code width, signed two's complement.
- `LSB`, 1.0/128: real value of one code step. Full scale is −1.0 … +127/128.
- `DECIM`, 4: samples per window. Legal range is 2–256.
- `SW`, NBITS+$clog2(DECIM): width of the window sum.
- `clk` in 1: sampling clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in` in xreal: analog input, typically the adder output.
- `code` out NBITS: latest quantized sample, registered.
- `sum` out SW: completed window sum, signed.
- `sum_valid` out 1: `sum` holds an unconsumed result.
- `sum_ready` in 1: downstream accepts `sum` on any edge where valid and ready are both high.
- `overrun` out 1: sticky flag; a window result was dropped.
- `sat` out 1: sticky flag; a sample clipped. Present only with `XDS_SAT_FLAG_EN`.

## Operation
- Quantize: q = round(in/LSB), round-to-nearest, ties away from zero. Clamp q to [−2^(NBITS−1), 2^(NBITS−1)−1].
- The `in` value used is the one at the rising `clk` edge.
- Internal state:
  - `cnt`, 0..DECIM−1.
  - `acc`, SW bits, signed.
  - Output register (`sum`, `sum_valid`).
- FSM has two states:
  - FILL: `acc` accumulates and `cnt` advances.
  - DUMP: entered on the edge where `cnt` = DECIM−1. `acc+q` goes to the output path, `acc` ← 0, `cnt` ← 0, and the FSM returns to FILL on the same edge. DUMP is a single edge event, not a dwell state.
- Output register on a dump edge:
  - If `sum_valid`=0, or `sum_valid`=1 and `sum_ready`=1 on that edge: `sum` ← acc+q and `sum_valid` ← 1.
  - If `sum_valid`=1 and `sum_ready`=0: the new result is discarded, `sum` and `sum_valid` keep their old values, and `overrun` ← 1.
- On a non-dump edge where `sum_valid`=1 and `sum_ready`=1: `sum_valid` ← 0 and `sum` holds its value.
- SW is sized so the window sum never overflows. Worst cases are DECIM·(−2^(NBITS−1)) and DECIM·(2^(NBITS−1)−1).
- `sum_ready` is ignored while `sum_valid`=0.

## Timing
- Reset values (asynchronous, immediate on `rst`=1):
  - `code`=0, `sum`=0, `sum_valid`=0.
  - `cnt`=0, `acc`=0.
  - `overrun`=0, `sat`=0.
  - Outputs hold these values while `rst`=1.
- Reset mid-window: the partial `acc` is discarded. The first window after `rst` falls uses the first DECIM rising edges after deassertion.
- `code` is valid one edge after the sample, i.e. it updates on the sampling edge.
- `sum_valid` rises on the DECIM-th sampling edge of a window. Latency from a window's first sample to valid is DECIM−1 edges.
- Back-to-back: with `sum_ready` tied high, `sum_valid` is high for 1 cycle in every DECIM cycles.
- Simultaneous accept and dump on the same edge: the new sum is loaded, `sum_valid` stays 1, and no overrun is flagged.

## Configuration
- Macro: `XDS_SAT_FLAG_EN`.
- Defined:
  - Port `sat` exists.
  - `sat` is set to 1 on any edge where the unclamped q falls outside the code range.
  - `sat` is sticky until `rst`.
- Undefined:
  - Port `sat` and its logic are absent.
  - Clamping behaviour is unchanged.

## Test plan
Defaults apply: NBITS=8, LSB=1/128, DECIM=4, `sum_ready`=1 unless stated.
- Constant `in`=0.5, release `rst`:
  - `code`=64 after the first edge.
  - `sum`=256 with `sum_valid` pulsing once every 4 edges.
  - `overrun`=0 throughout.
- Saturation, `in`=1.2 then `in`=−2.0:
  - For 1.2: `code`=127, `sum`=508.
  - For −2.0: `code`=−128, `sum`=−512.
  - `sat`=1 when built with `XDS_SAT_FLAG_EN`.
- Rounding: `in` = 0.5·LSB → `code`=1; `in` = −0.5·LSB → `code`=−1; `in` = 0.49·LSB → `code`=0.
- Backpressure: hold `sum_ready`=0 through 2 windows with `in`=0.25.
  - `sum`=128 (first window) and `sum_valid` stays 1.
  - `overrun`=1 at the second dump edge.
  - Raising `sum_ready` clears `sum_valid` on the next edge.
- Reset mid-window:
  - Stimulus: `in`=0.5 for 2 edges, assert `rst` asynchronously between edges, release, then `in`=0.125.
  - All outputs go to 0 immediately when `rst` asserts.
  - The first post-reset `sum`=64, with no residue from the aborted window.
- Sine input (50 MHz, amp 1.0, plus 500 MHz, amp 0.2) sampled at 1 GHz: every `sum` equals the software sum of 4 rounded, clamped samples, checked by a model over 1000 windows.
